// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_stage #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0040_0000
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0040_0180
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Jump,
    input  logic [25:0]           JumpTarget,
    input  logic                  JumpReg,
    input  logic [DATA_WIDTH-1:0] RegTarget,
    output logic [DATA_WIDTH-1:0] PcAddress,
    input  logic [DATA_WIDTH-1:0] InstructionIn,
    output logic [DATA_WIDTH-1:0] IfIdInstruction,
    output logic [DATA_WIDTH-1:0] IfIdPcPlus4,
    output logic                  IfIdValid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  FetchFault
`endif
);

    localparam int unsigned REGION_LSB = 28;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic [DATA_WIDTH-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic                  if_id_valid_q, if_id_valid_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jump_target;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  redirect;
    logic                  trap;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  fetch_fault_q, fetch_fault_d;
`endif

    // Next-PC selection and IF/ID update; redirects take precedence over Stall.
    always_comb begin
        pc_plus4         = pc_q + DATA_WIDTH'(4);
        jump_target      = {if_id_pc_plus4_q[DATA_WIDTH-1:REGION_LSB], JumpTarget, 2'b00};
        redirect         = JumpReg | BranchTaken | Jump;
        redirect_target  = jump_target;
        trap             = 1'b0;
        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;

        if (JumpReg) begin
            redirect_target = RegTarget;
        end else if (BranchTaken) begin
            redirect_target = BranchTarget;
        end

        if (redirect) begin
            pc_d = redirect_target;
        end else if (!Stall) begin
            pc_d = pc_plus4;
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        trap          = redirect && (redirect_target[1:0] != 2'b00);
        fetch_fault_d = fetch_fault_q | trap;
        if (trap) begin
            pc_d = TRAP_VECTOR;
        end
`endif

        // A trapping redirect squashes the instruction fetched alongside it.
        if (Flush || trap) begin
            if_id_instr_d    = '0;
            if_id_pc_plus4_d = '0;
            if_id_valid_d    = 1'b0;
        end else if (!Stall) begin
            if_id_instr_d    = InstructionIn;
            if_id_pc_plus4_d = pc_plus4;
            if_id_valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            if_id_instr_q    <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_valid_q    <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_fault_q <= 1'b0;
        end else begin
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign FetchFault = fetch_fault_q;
`endif

    assign PcAddress       = pc_q;
    assign IfIdInstruction = if_id_instr_q;
    assign IfIdPcPlus4     = if_id_pc_plus4_q;
    assign IfIdValid       = if_id_valid_q;

endmodule
